// File: rtl/pipe_pkg.sv
// Shared sizing helpers for the elastic delay pipe.
package pipe_pkg;

  // Bits needed to hold an occupancy value in the range 0..stages.
  function automatic int cnt_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the delay pipe.
// Data only moves when a valid word arrives, so bubbles never overwrite held data.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr_i) begin
      // Flush drops the word but keeps the data register untouched.
      v_d = 1'b0;
    end else if (load_i) begin
      v_d = v_i;
      if (v_i) begin
        d_d = d_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/elastic_delay_pipe.sv
// Elastic delay line: STAGES registered stages with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module elastic_delay_pipe
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [cnt_width(STAGES)-1:0]   count,
  output logic                           empty,
  output logic                           full
);

  localparam int CW = cnt_width(STAGES);

  logic [STAGES-1:0] stage_v;
  logic [WIDTH-1:0]  stage_d [STAGES];
  logic [STAGES-1:0] adv;
  logic              all_v;

  logic          in_xfer, out_xfer;
  logic [CW-1:0] count_q, count_d;

  // Stage i may advance unless it and every stage downstream of it are
  // occupied with the output stalled; written flat to avoid a feedback vector.
  always_comb begin
    adv   = '0;
    all_v = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      all_v = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        all_v = all_v & stage_v[j];
      end
      adv[i] = out_ready | ~all_v;
    end
  end

  assign in_ready = adv[0] & ~flush & ~reset;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (g == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = stage_v[g-1];
      assign up_d = stage_d[g-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (flush),
      .load_i (adv[g]),
      .v_i    (up_v),
      .d_i    (up_d),
      .v_o    (stage_v[g]),
      .d_o    (stage_d[g])
    );
  end

  assign out_valid = stage_v[STAGES-1];
  assign out_data  = stage_d[STAGES-1];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(STAGES));

endmodule

// File: doc/elastic_delay_pipe.md
# elastic_delay_pipe

Parametrised registered delay line that carries a WIDTH-bit word through STAGES register stages. It adds valid/ready backpressure, bubble collapsing, a synchronous flush and occupancy status, none of which the fixed single-register delay `q <= d` provides. It sits between a producer and a consumer in the datapath, wherever a known minimum latency and elastic buffering of up to STAGES words are needed.

## Interface
- WIDTH, 8: data width in bits; must be ≥1.
- STAGES, 2: number of register stages; this is both the minimum latency and the capacity. Must be ≥1.
- clk  input  1  the single clock; all state changes on its posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held words.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  output word; equals the last stage's data register.
- count  output  $clog2(STAGES+1)  number of words held.
- empty  output  1  count==0.
- full  output  1  count==STAGES.

## Operation
- Stages are indexed 0 (input side) to STAGES-1 (output side). Each stage holds a valid bit v[i] and a data register d[i].
- Advance enable:
  - adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
- in_ready = adv[0] & !flush & !reset.
- When adv[i] is high, stage i loads from stage i-1 (stage 0 loads from in_valid/in_data):
  - v[i] takes the upstream valid.
  - d[i] loads only if the upstream valid is 1; otherwise d[i] holds.
- Bubbles collapse. An empty stage always accepts, so words compact toward the output while the output is stalled.
- out_valid = v[STAGES-1].
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready & !flush.
- count is a register:
  - Increments on an input transfer only.
  - Decrements on an output transfer only.
  - Holds when both or neither occur.
  - Never wraps; the 0 and STAGES bounds are unreachable beyond by construction.
- empty and full are decoded from the count register.
- full does not imply in_ready=0. When out_ready=1 every stage advances, so a full pipe still accepts one word per cycle.
- Flush:
  - While flush=1, in_ready is forced to 0, so no input transfer occurs.
  - An output handshake in a flush cycle is not counted.
  - At the next edge all v[i]=0 and count=0; d[i] hold their values.
- Reset:
  - Clears all v[i] and d[i] to 0 and count to 0.
  - Reset dominates flush.
- Reset values of outputs: out_valid=0, out_data=0, count=0, empty=1, full=0.
- in_ready is 0 while reset=1 and 1 in the first cycle after reset deasserts.

## Timing
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles, when downstream stages are free.
- Throughput: one word per cycle sustained with out_ready=1.
- Combinational path: in_ready depends on out_ready, flush and reset through the adv chain, which is O(STAGES) deep.
- Registered outputs: out_valid, out_data, count, empty and full carry no combinational input dependency.
- Order: strict FIFO order; no word is duplicated or dropped except by flush or reset.
- Simultaneous events:
  - Input and output transfer in the same cycle: count unchanged.
  - flush with in_valid=1: the input word is not accepted and the producer must hold it.

## Structure
- Package pipe_pkg holds the count-width constant function (clog2 of STAGES+1). No typedefs are needed.
- Sub-module pipe_stage: one v/d register pair with load enable and synchronous clear. It is instantiated STAGES times in a generate loop.
- The top level holds the adv chain, the count register and the status decode.

## Test plan
- Reset: hold reset for 3 cycles with in_valid=1 → in_ready=0 during reset, out_valid=0, count=0, empty=1, full=0; in_ready=1 on the first cycle after deassert.
- Streaming: STAGES=3, WIDTH=8, out_ready=1, push 0x11, 0x22, 0x33 on consecutive cycles → 0x11 is valid 3 cycles after its accept, then 0x22 and 0x33 follow back-to-back; count peaks at 3.
- Backpressure: out_ready=0, offer 5 words → 3 accepted, full=1, count=3, in_ready=0. Raise out_ready → in_ready=1 the same cycle, and the words drain in order.
- Bubble collapse: out_ready=0, push A, idle 2 cycles, push B → A at the output after 3 cycles, count=2, and B sits directly behind A (stage 1). Raise out_ready → B emerges the cycle after A.
- Flush: count=2 and in_valid=1 with flush=1 for one cycle → no accept that cycle; next cycle count=0, empty=1, out_valid=0, and out_data holds its prior value.
- Full with push and pop: count=3, in_valid=1, out_ready=1 for 4 cycles → count stays 3, one word leaves per cycle, and the output sequence matches input order.
